// File: rtl/useq_addr_sequencer.sv
// Microprogram sequencer: registered micro-PC with a return-address stack, conditional
// branches on selectable flags, a hardware loop counter, a stall input and sticky stack error.
module useq_addr_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 8,
    parameter int N_COND      = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [2:0]                         next_sel,
    input  logic [ADDR_W-1:0]                  branch_addr,
    input  logic [ADDR_W-1:0]                  map_addr,
    input  logic [N_COND-1:0]                  cond_in,
    input  logic [$clog2(N_COND)-1:0]          cond_sel,
    input  logic                               cond_pol,
    input  logic                               loop_load,
    input  logic [CNT_W-1:0]                   loop_cnt_in,
    input  logic                               stall,
    output logic [ADDR_W-1:0]                  upc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stack_err,
    output logic                               loop_zero
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);

    localparam logic [2:0] SEL_INC    = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_CALL   = 3'd2;
    localparam logic [2:0] SEL_RET    = 3'd3;
    localparam logic [2:0] SEL_MAP    = 3'd4;
    localparam logic [2:0] SEL_CBR    = 3'd5;
    localparam logic [2:0] SEL_LOOP   = 3'd6;

    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] inc;
    logic [PTR_W-1:0]  push_idx, pop_idx;
    logic              push_en;
    logic              flag;
    logic              full, empty;

    assign full     = (lvl_q == FULL_LVL);
    assign empty    = (lvl_q == '0);
    assign push_idx = lvl_q[PTR_W-1:0];
    assign pop_idx  = PTR_W'(lvl_q - 1'b1);

    // Out-of-range flag selects fall back to flag 0.
    always_comb begin
        flag = cond_in[0];
        if (int'(cond_sel) < N_COND) flag = cond_in[cond_sel];
    end

    always_comb begin
        inc     = upc_q + 1'b1;
        upc_d   = upc_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (!stall) begin
            case (next_sel)
                SEL_INC:    upc_d = inc;
                SEL_BRANCH: upc_d = branch_addr;
                SEL_MAP:    upc_d = map_addr;
                SEL_CALL: begin
                    if (full) begin
                        err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        lvl_d   = lvl_q + 1'b1;
                        upc_d   = branch_addr;
                    end
                end
                SEL_RET: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        lvl_d = lvl_q - 1'b1;
                        upc_d = stack_q[pop_idx];
                    end
                end
                SEL_CBR:    upc_d = (flag ^ cond_pol) ? branch_addr : inc;
                SEL_LOOP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        upc_d = branch_addr;
                    end else begin
                        upc_d = inc;
                    end
                end
                default:    upc_d = upc_q;
            endcase
            // A load overrides a same-cycle decrement; the branch above used the old count.
            if (loop_load) cnt_d = loop_cnt_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upc_q <= RESET_VEC;
            lvl_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            upc_q <= upc_d;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) stack_q[push_idx] <= inc;
    end

    assign upc         = upc_q;
    assign stack_level = lvl_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;
    assign loop_zero   = (cnt_q == '0);

endmodule
